// File: rtl/apb_node_watchdog.sv
// APB 1-to-N interconnect node: address decode, decode-error termination,
// PREADY watchdog abort and sticky first-error capture.

package apb_node_watchdog_pkg;
    localparam int MAP_W = 4096;

    // Packed default address map: field i = 32'h1A10_0000 + i*32'h1000 + offset.
    function automatic logic [MAP_W-1:0] addr_map(input int nb, input int aw, input logic [63:0] offset);
        logic [MAP_W-1:0] m;
        logic [63:0]      v;
        m = '0;
        for (int i = 0; i < nb; i++) begin
            v = 64'h1A10_0000 + 64'(i) * 64'h1000 + offset;
            for (int b = 0; b < aw; b++) begin
                if (b < 64) m[i*aw+b] = v[b];
            end
        end
        return m;
    endfunction
endpackage

module apb_node_watchdog
    import apb_node_watchdog_pkg::*;
#(
    parameter int NB_SLAVE       = 10,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] START_ADDR =
        (NB_SLAVE*APB_ADDR_WIDTH)'(addr_map(NB_SLAVE, APB_ADDR_WIDTH, 64'h0)),
    parameter logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] END_ADDR =
        (NB_SLAVE*APB_ADDR_WIDTH)'(addr_map(NB_SLAVE, APB_ADDR_WIDTH, 64'hFFF))
)(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [APB_ADDR_WIDTH-1:0]          m_paddr,
    input  logic [APB_DATA_WIDTH-1:0]          m_pwdata,
    input  logic                               m_pwrite,
    input  logic                               m_psel,
    input  logic                               m_penable,
    output logic [APB_DATA_WIDTH-1:0]          m_prdata,
    output logic                               m_pready,
    output logic                               m_pslverr,
    output logic [APB_ADDR_WIDTH-1:0]          s_paddr,
    output logic [APB_DATA_WIDTH-1:0]          s_pwdata,
    output logic                               s_pwrite,
    output logic                               s_penable,
    output logic [NB_SLAVE-1:0]                s_psel,
    input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0] s_prdata,
    input  logic [NB_SLAVE-1:0]                s_pready,
    input  logic [NB_SLAVE-1:0]                s_pslverr,
    output logic                               err_valid_o,
    output logic                               err_type_o,
    output logic [APB_ADDR_WIDTH-1:0]          err_addr_o,
    input  logic                               err_clr_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int IDX_W = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DECERR, ST_TOUT} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_valid_q, err_type_q;
    logic [APB_ADDR_WIDTH-1:0] err_addr_q;
    logic                      raise_err, raise_type;
    logic                      hit;
    logic [IDX_W-1:0]          hit_idx;

    assign s_paddr     = m_paddr;
    assign s_pwdata    = m_pwdata;
    assign s_pwrite    = m_pwrite;
    assign s_penable   = m_penable;
    assign err_valid_o = err_valid_q;
    assign err_type_o  = err_type_q;
    assign err_addr_o  = err_addr_q;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NB_SLAVE - 1; i >= 0; i--) begin
            if (m_paddr >= START_ADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
                m_paddr <= END_ADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        s_psel     = '0;
        m_prdata   = '0;
        m_pready   = 1'b0;
        m_pslverr  = 1'b0;
        raise_err  = 1'b0;
        raise_type = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (m_psel && !m_penable) begin
                    if (hit) begin
                        // Gated so a SETUP presented during reset never reaches a slave.
                        s_psel[hit_idx] = rst_n;
                        idx_d           = hit_idx;
                        state_d         = ST_ACCESS;
                    end else begin
                        state_d = ST_DECERR;
                    end
                end
            end
            ST_ACCESS: begin
                s_psel[idx_q] = m_psel;
                m_prdata      = s_prdata[idx_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                m_pready      = s_pready[idx_q];
                m_pslverr     = s_pslverr[idx_q];
                if (!m_psel || s_pready[idx_q]) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (WDOG_EN && cnt_q == CNT_LAST) begin
                    state_d = ST_TOUT;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECERR: begin
                m_pready  = 1'b1;
                m_pslverr = 1'b1;
                raise_err = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_TOUT: begin
                m_pready   = 1'b1;
                m_pslverr  = 1'b1;
                raise_err  = 1'b1;
                raise_type = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clear coinciding with a new error lets the new error in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_type_q  <= 1'b0;
            err_addr_q  <= '0;
        end else if (raise_err && (!err_valid_q || err_clr_i)) begin
            err_valid_q <= 1'b1;
            err_type_q  <= raise_type;
            err_addr_q  <= m_paddr;
        end else if (err_clr_i) begin
            err_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_node_watchdog.sv
// Directed bench for apb_node_watchdog: transaction-level expectations checked
// every cycle, plus literal checks on cycle counts and captured errors.

module tb_apb_node_watchdog;
    localparam int NB = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] m_paddr = '0;
    logic [DW-1:0] m_pwdata = '0;
    logic          m_pwrite = 1'b0, m_psel = 1'b0, m_penable = 1'b0;
    logic [DW-1:0] m_prdata;
    logic          m_pready, m_pslverr;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata;
    logic          s_pwrite, s_penable;
    logic [NB-1:0] s_psel, s_pready, s_pslverr;
    logic [NB*DW-1:0] s_prdata;
    logic          err_valid_o, err_type_o, err_clr_i = 1'b0;
    logic [AW-1:0] err_addr_o;

    always #5 clk = ~clk;

    apb_node_watchdog #(
        .NB_SLAVE(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
        .m_psel(m_psel), .m_penable(m_penable),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite), .s_penable(s_penable),
        .s_psel(s_psel), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .err_valid_o(err_valid_o), .err_type_o(err_type_o), .err_addr_o(err_addr_o),
        .err_clr_i(err_clr_i)
    );

    // Bench slaves: slave i inserts wait_cfg[i] wait states, 100 means never ready.
    int acc_cnt  [NB];
    int wait_cfg [NB] = '{0, 2, 1, 100, 3, 0, 0, 0};
    bit serr_cfg [NB] = '{0, 0, 1, 0, 0, 0, 0, 0};

    function automatic logic [31:0] rdat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < NB; i++) begin
            s_prdata[i*DW +: DW] = rdat(i);
            acc_cnt[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (s_psel[i] && s_penable) begin
                if (!s_pready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
            end else begin
                acc_cnt[i] <= 0;
            end
        end
    end

    always_comb begin
        s_pready  = '0;
        s_pslverr = '0;
        for (int i = 0; i < NB; i++) begin
            s_pready[i]  = s_psel[i] && s_penable && (acc_cnt[i] >= wait_cfg[i]);
            s_pslverr[i] = s_pready[i] && serr_cfg[i];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected upstream/slave-select view for the current cycle, plus error model.
    logic [NB-1:0] e_psel = '0;
    logic          e_pready = 1'b0, e_slverr = 1'b0;
    logic [31:0]   e_prdata = '0;
    bit            me_v = 1'b0, me_t = 1'b0;
    logic [31:0]   me_a = '0;
    bit            chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("s_psel",     32'(s_psel),      32'(e_psel));
            check("m_pready",   32'(m_pready),    32'(e_pready));
            check("m_pslverr",  32'(m_pslverr),   32'(e_slverr));
            check("m_prdata",   m_prdata,         e_prdata);
            check("err_valid",  32'(err_valid_o), 32'(me_v));
            check("err_type",   32'(err_type_o),  32'(me_t));
            check("err_addr",   err_addr_o,       me_a);
            check("s_paddr",    s_paddr,          m_paddr);
            check("s_pwdata",   s_pwdata,         m_pwdata);
            check("s_ctrl",     {30'h0, s_pwrite, s_penable}, {30'h0, m_pwrite, m_penable});
        end
    end

    task automatic set_exp(input logic [NB-1:0] ps, input logic pr, input logic se, input logic [31:0] rd);
        e_psel = ps; e_pready = pr; e_slverr = se; e_prdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic err_cycle(input bit t, input logic [31:0] a, input bit clr);
        err_clr_i = clr;
        @(posedge clk);
        if (!me_v || clr) begin
            me_v = 1'b1; me_t = t; me_a = a;
        end
        #1;
        err_clr_i = 1'b0;
    endtask

    task automatic clear_err();
        set_exp('0, 1'b0, 1'b0, 32'h0);
        err_clr_i = 1'b1;
        @(posedge clk);
        me_v = 1'b0;
        #1;
        err_clr_i = 1'b0;
    endtask

    function automatic int slave_of(input logic [31:0] a);
        for (int i = 0; i < NB; i++) begin
            if (a >= 32'h1A10_0000 + 32'(i) * 32'h1000 && a <= 32'h1A10_0000 + 32'(i) * 32'h1000 + 32'hFFF)
                return i;
        end
        return -1;
    endfunction

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input bit clr, output int ncyc);
        int j;
        bit rdy;
        j = slave_of(addr);
        ncyc = 1;
        m_paddr = addr; m_pwrite = wr; m_pwdata = wdata; m_psel = 1'b1; m_penable = 1'b0;
        set_exp((j >= 0) ? NB'(1 << j) : '0, 1'b0, 1'b0, 32'h0);
        tick();
        m_penable = 1'b1;
        if (j < 0) begin
            set_exp('0, 1'b1, 1'b1, 32'h0);
            err_cycle(1'b0, addr, clr);
            ncyc++;
        end else begin
            for (int k = 1; k <= T; k++) begin
                rdy = (k == wait_cfg[j] + 1);
                set_exp(NB'(1 << j), rdy, rdy & serr_cfg[j], rdat(j));
                tick();
                ncyc++;
                if (rdy) break;
                if (k == T) begin
                    set_exp('0, 1'b1, 1'b1, 32'h0);
                    err_cycle(1'b1, addr, clr);
                    ncyc++;
                end
            end
        end
        m_psel = 1'b0; m_penable = 1'b0;
        set_exp('0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"},    32'(s_psel),      32'h0);
        check({tag, "_pready"},  32'(m_pready),    32'h0);
        check({tag, "_pslverr"}, 32'(m_pslverr),   32'h0);
        check({tag, "_prdata"},  m_prdata,         32'h0);
        check({tag, "_evalid"},  32'(err_valid_o), 32'h0);
        check({tag, "_etype"},   32'(err_type_o),  32'h0);
        check({tag, "_eaddr"},   err_addr_o,       32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "tb_apb_node_watchdog stuck");
    end

    initial begin
        int n;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_exp('0, 1'b0, 1'b0, 32'h0);
        chk_en = 1'b1;
        tick();

        xfer(32'h1A10_1004, 1'b1, 32'hDEAD_BEEF, 1'b0, n);
        check("wr_cycles", 32'(n), 32'd4);
        check("wr_noerr", 32'(err_valid_o), 32'd0);

        xfer(32'h1A10_9000, 1'b0, 32'h0, 1'b0, n);
        check("decerr_cycles", 32'(n), 32'd2);
        check("decerr_valid", 32'(err_valid_o), 32'd1);
        check("decerr_type", 32'(err_type_o), 32'd0);
        check("decerr_addr", err_addr_o, 32'h1A10_9000);
        clear_err();
        check("clr_valid", 32'(err_valid_o), 32'd0);

        xfer(32'h1A10_3000, 1'b0, 32'h0, 1'b0, n);
        check("tout_cycles", 32'(n), 32'd6);
        check("tout_valid", 32'(err_valid_o), 32'd1);
        check("tout_type", 32'(err_type_o), 32'd1);
        check("tout_addr", err_addr_o, 32'h1A10_3000);
        clear_err();

        xfer(32'h1A10_4010, 1'b0, 32'h0, 1'b0, n);
        check("edge_ready_cycles", 32'(n), 32'd5);
        check("edge_ready_noerr", 32'(err_valid_o), 32'd0);

        xfer(32'h1A10_2008, 1'b1, 32'h1234_5678, 1'b0, n);
        check("slverr_cycles", 32'(n), 32'd3);
        check("slverr_noerr", 32'(err_valid_o), 32'd0);

        xfer(32'h1A10_0000, 1'b0, 32'h0, 1'b0, n);
        check("lo_bound_cycles", 32'(n), 32'd2);
        xfer(32'h1A10_7FFC, 1'b1, 32'hA5A5_5A5A, 1'b0, n);
        check("hi_bound_cycles", 32'(n), 32'd2);

        xfer(32'h1A0F_FFFC, 1'b0, 32'h0, 1'b0, n);
        xfer(32'h1A10_8000, 1'b0, 32'h0, 1'b0, n);
        check("sticky_addr", err_addr_o, 32'h1A0F_FFFC);
        check("sticky_type", 32'(err_type_o), 32'd0);
        xfer(32'h1A10_3ABC, 1'b0, 32'h0, 1'b1, n);
        check("clr_new_addr", err_addr_o, 32'h1A10_3ABC);
        check("clr_new_type", 32'(err_type_o), 32'd1);
        check("clr_new_valid", 32'(err_valid_o), 32'd1);

        // Master abandons an ACCESS to the never-ready slave.
        m_paddr = 32'h1A10_3000; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
        set_exp(NB'(8), 1'b0, 1'b0, 32'h0);
        tick();
        m_penable = 1'b1;
        set_exp(NB'(8), 1'b0, 1'b0, rdat(3));
        tick();
        m_psel = 1'b0; m_penable = 1'b0;
        set_exp('0, 1'b0, 1'b0, rdat(3));
        tick();
        set_exp('0, 1'b0, 1'b0, 32'h0);
        tick();
        check("abort_noerr", err_addr_o, 32'h1A10_3ABC);
        xfer(32'h1A10_0100, 1'b0, 32'h0, 1'b0, n);
        check("post_abort_cycles", 32'(n), 32'd2);

        // Reset while an ACCESS is in flight.
        m_paddr = 32'h1A10_3000; m_psel = 1'b1; m_penable = 1'b0;
        set_exp(NB'(8), 1'b0, 1'b0, 32'h0);
        tick();
        m_penable = 1'b1;
        set_exp(NB'(8), 1'b0, 1'b0, rdat(3));
        tick();
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_psel = 1'b0; m_penable = 1'b0;
        me_v = 1'b0; me_t = 1'b0; me_a = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_exp('0, 1'b0, 1'b0, 32'h0);
        chk_en = 1'b1;
        tick();
        xfer(32'h1A10_5020, 1'b1, 32'h0BAD_F00D, 1'b0, n);
        check("post_reset_cycles", 32'(n), 32'd2);
        check("post_reset_noerr", 32'(err_valid_o), 32'd0);
        tick();
        tick();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_node_watchdog.md
# apb_node_watchdog

- Parametrised 1-to-NB_SLAVE APB interconnect node for the SoC peripheral bus.
- Decodes each transfer against per-slave address ranges and routes it to one slave.
- Terminates transfers to unmapped addresses with an error. Aborts any slave that holds PREADY low longer than a programmable bound, also with an error.
- Captures the first error's address and type for software. Sits between the core-side APB bridge and the peripherals (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC ctrl, FPU, debug).

## Interface
Parameters:
- NB_SLAVE, 10, number of slave ports.
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without PREADY; 0 disables the watchdog.
- START_ADDR, packed NB_SLAVE*APB_ADDR_WIDTH, default slave i = 32'h1A10_0000 + i*32'h1000, inclusive lower bound of slave i.
- END_ADDR, packed NB_SLAVE*APB_ADDR_WIDTH, default START_ADDR[i] + 32'hFFF, inclusive upper bound of slave i.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m_paddr / m_pwdata / m_pwrite / m_psel / m_penable  in  ADDR/DATA/1/1/1  upstream master request.
- m_prdata / m_pready / m_pslverr  out  DATA/1/1  upstream response.
- s_paddr / s_pwdata / s_pwrite / s_penable  out  ADDR/DATA/1/1  broadcast to all slaves.
- s_psel  out  NB_SLAVE  one-hot slave select.
- s_prdata  in  NB_SLAVE*DATA  packed slave read data; slave i at [i*DATA +: DATA].
- s_pready / s_pslverr  in  NB_SLAVE  per-slave response.
- err_valid_o  out  1  sticky error flag.
- err_type_o  out  1  0 = decode error, 1 = timeout.
- err_addr_o  out  ADDR  address of the captured error.
- err_clr_i  in  1  clears the error capture.

## Operation
- Decode: hit[i] = START_ADDR[i] <= m_paddr <= END_ADDR[i]. The lowest index wins on overlap. The decode is combinational, used only in the SETUP cycle.
- s_paddr, s_pwdata, s_pwrite and s_penable are wired straight from the master inputs.
- FSM states: IDLE, ACCESS, DECERR, TOUT.
- IDLE
  - m_pready=0, m_pslverr=0, m_prdata=0.
  - On m_psel=1 && m_penable=0 with a hit: s_psel[idx]=1 combinationally, idx is registered, next state ACCESS.
  - On m_psel=1 && m_penable=0 with a miss: no s_psel, next state DECERR.
- ACCESS
  - s_psel[idx_q]=m_psel.
  - m_prdata, m_pready and m_pslverr are muxed from slave idx_q.
  - Watchdog counter increments on every ACCESS cycle with s_pready[idx_q]=0.
  - On s_pready[idx_q]=1: next state IDLE, counter cleared.
  - On pready=0 with counter == TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES != 0: next state TOUT.
  - On m_psel=0 (master abort): next state IDLE, counter cleared, no error.
- DECERR: all s_psel=0; m_pready=1, m_pslverr=1, m_prdata=0 for one cycle; next state IDLE; raise decode-error capture.
- TOUT: all s_psel=0; m_pready=1, m_pslverr=1, m_prdata=0 for one cycle; next state IDLE; raise timeout capture.
- Error capture
  - If err_valid_o=0 and an error is raised, the node latches err_valid_o=1, err_type_o and err_addr_o=m_paddr.
  - Later errors are ignored while err_valid_o=1.
  - err_clr_i clears err_valid_o. If a clear and a new error occur in the same cycle, the new error is captured.
- Counter width is $clog2(TIMEOUT_CYCLES+1), with minimum 1. The counter saturates and never wraps.

## Timing
- Reset values:
  - State IDLE, counter 0, idx_q 0.
  - All s_psel=0, m_pready=0, m_pslverr=0, m_prdata=0.
  - err_valid_o=0, err_type_o=0, err_addr_o=0.
- Reset asserted mid-transfer returns the node to IDLE immediately. Outputs take their reset values asynchronously.
- Zero added latency for mapped transfers: slave sees psel in the master's SETUP cycle, and PREADY passes through in the same cycle.
- A decode error completes in exactly 2 cycles: SETUP, then DECERR with pready=1.
- A timed-out transfer lasts 1 (SETUP) + TIMEOUT_CYCLES (ACCESS, pready=0) + 1 (TOUT) cycles.
- A slave asserting pready in ACCESS cycle number TIMEOUT_CYCLES completes normally; the deadline is exclusive of that cycle.
- Error flags update on the clock edge that ends the DECERR or TOUT cycle.
- Back-to-back transfers: a new SETUP is accepted in the cycle right after the completion cycle.

## Test plan
- Write 32'hDEAD_BEEF to 32'h1A10_1004 (slave 1, pready after 2 wait states):
  - only s_psel[1] asserts;
  - m_pready=1 on the 3rd ACCESS cycle with pslverr=0;
  - err_valid_o stays 0.
- Read 32'h1A10_9000 (unmapped):
  - no s_psel;
  - the cycle after SETUP gives m_pready=1, m_pslverr=1, m_prdata=0;
  - err_valid_o=1, err_type_o=0, err_addr_o=32'h1A10_9000.
- TIMEOUT_CYCLES=4, slave 3 never ready:
  - s_psel[3] drops after 4 ACCESS cycles;
  - TOUT cycle gives pready=1, pslverr=1;
  - err_type_o=1, err_addr_o=32'h1A10_3000.
- TIMEOUT_CYCLES=4, slave ready in ACCESS cycle 4: normal completion, no error.
- Two errors before clear: the first address is retained. Pulse err_clr_i in the same cycle as a third error: the third error's address is captured.
- rst_n low during ACCESS: all outputs return to reset values. The next transfer after reset completes normally.
